blk_interleaver_pp: RTL and testbench
=====================================

BLK_INTERLEAVER_PP -- requirements
Module: blk_interleaver_pp

Interface
REQ-001 SHALL have parameter W, default 1, meaning symbol width in bits.
REQ-002 SHALL have parameter R, default 4, meaning rows per block (>=2).
REQ-003 SHALL have parameter C, default 4, meaning columns per block (>=2); block length N=R*C.
REQ-004 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port clr  input  1  synchronous clear of all state.
REQ-007 SHALL have port mode  input  1  0=interleave, 1=deinterleave.
REQ-008 SHALL have port in_valid  input  1  in_data offered.
REQ-009 SHALL have port in_ready  output  1  block can accept a symbol.
REQ-010 SHALL have port in_data  input  W  input symbol.
REQ-011 SHALL have port out_valid  output  1  out_data valid.
REQ-012 SHALL have port out_ready  input  1  sink accepts out_data.
REQ-013 SHALL have port out_data  output  W  output symbol.

Function
REQ-014 SHALL hold two banks of N symbols (ping-pong); one fills while the other drains.
REQ-015 SHALL accept a symbol on an edge where in_valid&&in_ready, writing it to the fill bank at write index k (0..N-1).
REQ-016 SHALL sample mode on the write of k=0 and store it per bank; mode changes mid-block have no effect on that block.
REQ-017 SHALL, for interleave, write address k and read address (j%R)*C + j/R for output index j (row-in, column-out).
REQ-018 SHALL, for deinterleave, write address k and read address (j%C)*R + j/C (inverse of REQ-017).
REQ-019 SHALL generate addresses with row/column counters and incremental adds; no dividers or multipliers.
REQ-020 SHALL mark a bank FULL on the edge writing k=N-1, then switch filling to the other bank if it is EMPTY.
REQ-021 SHALL deassert in_ready while both banks are FULL/DRAINING; reassert on the edge the drain bank becomes EMPTY.
REQ-022 SHALL register out_data/out_valid; first out_valid of a block appears the edge after the edge writing k=N-1 (drain bank was idle).
REQ-023 SHALL hold out_data and out_valid stable while out_valid&&!out_ready; advance j only on out_valid&&out_ready.
REQ-024 SHALL, on transfer of j=N-1, mark the bank EMPTY and, if the other bank is FULL, present its j=0 symbol the next edge (no bubble).
REQ-025 SHALL allow simultaneous write of k=N-1 into one bank and read of j=N-1 from the other in the same cycle, swapping both roles.
REQ-026 SHALL wrap k and j from N-1 to 0.
REQ-027 SHALL, on clr=1, act as reset on the next edge (clr has priority over in_valid/out_ready); partial blocks are discarded.

Reset
REQ-028 SHALL on rst=0 set out_valid=0, out_data=0, in_ready=1, both banks EMPTY, k=j=0, fill bank=0.
REQ-029 SHALL NOT require bank memory contents to be reset; EMPTY banks are never read.
REQ-030 SHALL discard any partial or undrained block on reset mid-operation; no output follows until a full new block is written.

Structure
REQ-031 SHALL place the mode encoding (ILV/DEILV), bank-state enum (EMPTY, FILLING, FULL, DRAINING) and default R/C/W in package ilv_pkg.
REQ-032 SHALL use one sub-module ilv_addr_gen (row/column counters -> read address, per mode, with wrap) instantiated for the read side.

Verification
REQ-033 SHALL verify R=C=4, W=4, mode=0, inputs 0..15 back-to-back -> outputs 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15.
REQ-034 SHALL verify R=2, C=3, mode=0, inputs 0..5 -> 0,3,1,4,2,5; then mode=1 on 0,3,1,4,2,5 -> 0..5.
REQ-035 SHALL verify continuous streaming of 3 blocks with out_ready=1 -> in_ready never drops, zero output bubbles between blocks.
REQ-036 SHALL verify out_ready=0 for 40 cycles after two blocks written -> in_ready=0, out_data held, no data lost once released.
REQ-037 SHALL verify rst=0 (and separately clr=1) after 7 of 16 inputs -> out_valid=0, then new block 16..31 yields correct permutation only.
REQ-038 SHALL verify mode toggled at k=5 -> whole block uses mode latched at k=0.

Source files
------------

// File: rtl/ilv_pkg.sv
// Shared types and defaults for the ping-pong block interleaver.
package ilv_pkg;

    typedef enum logic {
        ILV   = 1'b0,
        DEILV = 1'b1
    } ilv_mode_t;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    localparam int DEF_W = 1;
    localparam int DEF_R = 4;
    localparam int DEF_C = 4;

endpackage

// File: rtl/ilv_addr_gen.sv
// Read-address walker for one block: steps through the bank in permuted order
// using a period counter, a column counter and a running address (adds only).
module ilv_addr_gen
    import ilv_pkg::*;
#(
    parameter int R  = DEF_R,
    parameter int C  = DEF_C,
    parameter int AW = $clog2(R * C)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  ilv_mode_t     mode,
    input  logic          advance,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam logic [AW-1:0] ONE = AW'(1);

    logic [AW-1:0] cnt;
    logic [AW-1:0] col;
    logic [AW-1:0] period_m1;
    logic [AW-1:0] stride;

    // Interleave walks columns of an RxC array, deinterleave walks columns of CxR.
    assign period_m1 = (mode == DEILV) ? AW'(C - 1) : AW'(R - 1);
    assign stride    = (mode == DEILV) ? AW'(R) : AW'(C);
    assign last      = (cnt == period_m1) && (col == stride - ONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            col  <= '0;
            addr <= '0;
        end else if (clr) begin
            cnt  <= '0;
            col  <= '0;
            addr <= '0;
        end else if (advance) begin
            if (last) begin
                cnt  <= '0;
                col  <= '0;
                addr <= '0;
            end else if (cnt == period_m1) begin
                cnt  <= '0;
                col  <= col + ONE;
                addr <= col + ONE;
            end else begin
                cnt  <= cnt + ONE;
                addr <= addr + stride;
            end
        end
    end

endmodule

// File: rtl/blk_interleaver_pp.sv
// Ping-pong block interleaver/deinterleaver: one bank fills in natural order
// while the other drains through ilv_addr_gen into a registered output stage.
module blk_interleaver_pp
    import ilv_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int R = DEF_R,
    parameter int C = DEF_C
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         mode,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    localparam int N  = R * C;
    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] LAST_K = AW'(N - 1);
    localparam logic [AW-1:0] ONE    = AW'(1);

    bank_state_t   state     [2];
    bank_state_t   state_nxt [2];
    ilv_mode_t     bank_mode [2];
    logic [W-1:0]  mem       [2][N];
    logic          fill_bank;
    logic          drain_bank;
    logic [AW-1:0] k;
    logic [AW-1:0] rd_addr;
    logic          rd_last;
    logic          wr_en;
    logic          rd_en;

    assign in_ready = (state[fill_bank] == EMPTY) || (state[fill_bank] == FILLING);
    assign wr_en    = in_valid && in_ready;
    assign rd_en    = (!out_valid || out_ready) &&
                      ((state[drain_bank] == FULL) || (state[drain_bank] == DRAINING));

    // A bank is released once its last symbol sits in the output register,
    // which lets a finished fill and a finished drain swap roles on one edge.
    always_comb begin
        state_nxt[0] = state[0];
        state_nxt[1] = state[1];
        if (wr_en) begin
            state_nxt[fill_bank] = (k == LAST_K) ? FULL : FILLING;
        end
        if (rd_en) begin
            state_nxt[drain_bank] = rd_last ? EMPTY : DRAINING;
        end
    end

    ilv_addr_gen #(
        .R  (R),
        .C  (C),
        .AW (AW)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .mode    (bank_mode[drain_bank]),
        .advance (rd_en),
        .addr    (rd_addr),
        .last    (rd_last)
    );

    always_ff @(posedge clk) begin
        if (wr_en && !clr) begin
            mem[fill_bank][k] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state[0]     <= EMPTY;
            state[1]     <= EMPTY;
            bank_mode[0] <= ILV;
            bank_mode[1] <= ILV;
            fill_bank    <= 1'b0;
            drain_bank   <= 1'b0;
            k            <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
        end else if (clr) begin
            state[0]     <= EMPTY;
            state[1]     <= EMPTY;
            bank_mode[0] <= ILV;
            bank_mode[1] <= ILV;
            fill_bank    <= 1'b0;
            drain_bank   <= 1'b0;
            k            <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
        end else begin
            state[0] <= state_nxt[0];
            state[1] <= state_nxt[1];

            if (wr_en) begin
                k <= (k == LAST_K) ? '0 : k + ONE;
                if (k == '0) begin
                    bank_mode[fill_bank] <= ilv_mode_t'(mode);
                end
            end

            // Filling moves on only when the other bank is free to take it.
            if ((state_nxt[fill_bank] == FULL) && (state_nxt[~fill_bank] == EMPTY)) begin
                fill_bank <= ~fill_bank;
            end

            if (rd_en && rd_last) begin
                drain_bank <= ~drain_bank;
            end

            if (rd_en) begin
                out_valid <= 1'b1;
                out_data  <= mem[drain_bank][rd_addr];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_blk_interleaver_pp.sv
// Bench for blk_interleaver_pp: a 4x4 and a 2x3 instance share one input
// stream and are each scored against an index-formula reference model.
module tb_blk_interleaver_pp;

    localparam int W  = 4;
    localparam int BR = 4;
    localparam int BC = 4;
    localparam int SR = 2;
    localparam int SC = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         clr;
    logic         mode;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] in_data;
    logic         b_in_ready;
    logic         b_out_valid;
    logic [W-1:0] b_out_data;
    logic         s_in_ready;
    logic         s_out_valid;
    logic [W-1:0] s_out_data;

    int tests_run    = 0;
    int tests_failed = 0;

    int           mk    [2];
    logic         mmode [2];
    logic [W-1:0] part  [2][16];
    logic [W-1:0] exp_b [$];
    logic [W-1:0] exp_s [$];
    logic [W-1:0] cap_b [$];
    logic [W-1:0] cap_s [$];

    int golden_ilv [16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
    int small_in   [12] = '{0, 1, 2, 3, 4, 5, 0, 3, 1, 4, 2, 5};
    int small_out  [12] = '{0, 3, 1, 4, 2, 5, 0, 1, 2, 3, 4, 5};

    always #5 clk = ~clk;

    blk_interleaver_pp #(.W(W), .R(BR), .C(BC)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (b_in_ready),
        .in_data   (in_data),
        .out_valid (b_out_valid),
        .out_ready (out_ready),
        .out_data  (b_out_data)
    );

    blk_interleaver_pp #(.W(W), .R(SR), .C(SC)) dut_small (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (s_in_ready),
        .in_data   (in_data),
        .out_valid (s_out_valid),
        .out_ready (out_ready),
        .out_data  (s_out_data)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, expv);
        end
    endtask

    task automatic clearModel();
        mk[0] = 0;
        mk[1] = 0;
        exp_b.delete();
        exp_s.delete();
    endtask

    // Block complete: output j is the symbol written at the spec's read index.
    task automatic modelAccept(input int d, input logic [W-1:0] data, input logic m);
        int r;
        int c;
        int n;
        r = (d == 0) ? BR : SR;
        c = (d == 0) ? BC : SC;
        n = r * c;
        if (mk[d] == 0) mmode[d] = m;
        part[d][mk[d]] = data;
        mk[d]++;
        if (mk[d] == n) begin
            for (int j = 0; j < n; j++) begin
                int a;
                a = mmode[d] ? (j % c) * r + j / c : (j % r) * c + j / r;
                if (d == 0) exp_b.push_back(part[d][a]);
                else        exp_s.push_back(part[d][a]);
            end
            mk[d] = 0;
        end
    endtask

    task automatic checkOutput();
        if (b_out_valid && out_ready) begin
            chk("big_expected_pending", exp_b.size() != 0, 1);
            if (exp_b.size() != 0) begin
                chk("big_data", b_out_data, exp_b[0]);
                void'(exp_b.pop_front());
            end
            cap_b.push_back(b_out_data);
        end
        if (s_out_valid && out_ready) begin
            chk("small_expected_pending", exp_s.size() != 0, 1);
            if (exp_s.size() != 0) begin
                chk("small_data", s_out_data, exp_s[0]);
                void'(exp_s.pop_front());
            end
            cap_s.push_back(s_out_data);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic m,
                                 input logic ordy, input logic c);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        mode      = m;
        out_ready = ordy;
        clr       = c;
        #1;
        if (c) begin
            clearModel();
        end else begin
            checkOutput();
            if (v && b_in_ready) modelAccept(0, d, m);
            if (v && s_in_ready) modelAccept(1, d, m);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clr       = 1'b0;
        #1;
        clearModel();
        chk("rst_big_out_valid", b_out_valid, 0);
        chk("rst_big_out_data", b_out_data, 0);
        chk("rst_big_in_ready", b_in_ready, 1);
        chk("rst_small_out_valid", s_out_valid, 0);
        chk("rst_small_in_ready", s_in_ready, 1);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic drainAll(input string tag);
        int budget;
        budget = 300;
        while ((exp_b.size() != 0 || exp_s.size() != 0) && budget > 0) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
            budget--;
        end
        chk({tag, "_drained"}, exp_b.size() + exp_s.size(), 0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk({tag, "_idle"}, b_out_valid | s_out_valid, 0);
    endtask

    initial begin
        int  bubbles;
        int  budget;
        bit  seen;

        rst = 1'b0; clr = 1'b0; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        doReset();

        // 4x4 interleave of 0..15, back to back
        cap_b.delete();
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 4'(i), 1'b0, 1'b1, 1'b0);
        drainAll("ilv4x4");
        chk("ilv4x4_count", cap_b.size(), 16);
        for (int j = 0; j < 16; j++)
            if (j < cap_b.size()) chk("ilv4x4_order", cap_b[j], golden_ilv[j]);

        // 2x3 interleave then deinterleave
        doReset();
        cap_s.delete();
        for (int i = 0; i < 12; i++)
            applyStimulus(1'b1, 4'(small_in[i]), (i >= 6), 1'b1, 1'b0);
        drainAll("small");
        chk("small_count", cap_s.size(), 12);
        for (int j = 0; j < 12; j++)
            if (j < cap_s.size()) chk("small_order", cap_s[j], small_out[j]);

        // Three blocks streamed: first-output latency, no in_ready drop, no bubbles
        doReset();
        cap_b.delete();
        bubbles = 0;
        seen = 1'b0;
        for (int i = 0; i < 48; i++) begin
            applyStimulus(1'b1, 4'($urandom), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            chk("stream_in_ready", b_in_ready, 1);
            if (i == 16) chk("latency_before", b_out_valid, 0);
            if (i == 17) chk("latency_first", b_out_valid, 1);
            if (b_out_valid) seen = 1'b1;
            else if (seen && cap_b.size() < 48) bubbles++;
        end
        budget = 100;
        while (cap_b.size() < 48 && budget > 0) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
            if (!b_out_valid && cap_b.size() < 48) bubbles++;
            budget--;
        end
        chk("stream_outputs", cap_b.size(), 48);
        chk("stream_bubbles", bubbles, 0);
        drainAll("stream");

        // Sink stalled with two blocks stored
        doReset();
        for (int i = 0; i < 32; i++)
            applyStimulus(1'b1, 4'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        chk("stall_accepted", exp_b.size(), 32);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 4'($urandom), 1'b0, 1'b0, 1'b0);
            chk("stall_in_ready", b_in_ready, 0);
            chk("stall_out_valid", b_out_valid, 1);
            if (exp_b.size() != 0) chk("stall_hold", b_out_data, exp_b[0]);
        end
        drainAll("stall");

        // Reset after a partial block
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 4'(i), 1'b0, 1'b1, 1'b0);
        doReset();
        cap_b.delete();
        for (int i = 16; i < 32; i++) applyStimulus(1'b1, 4'(i), 1'b0, 1'b1, 1'b0);
        drainAll("after_rst");
        chk("after_rst_count", cap_b.size(), 16);

        // Clear after a partial block
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 4'(i + 3), 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("clr_out_valid", b_out_valid, 0);
        chk("clr_in_ready", b_in_ready, 1);
        cap_b.delete();
        for (int i = 16; i < 32; i++) applyStimulus(1'b1, 4'(i * 7), 1'b0, 1'b1, 1'b0);
        drainAll("after_clr");
        chk("after_clr_count", cap_b.size(), 16);

        // Mode toggled at k=5: the value latched at k=0 governs each block
        doReset();
        for (int i = 0; i < 18; i++) applyStimulus(1'b1, 4'($urandom), (i >= 5), 1'b1, 1'b0);
        drainAll("mode_latch");

        // Random traffic with random back-pressure and per-symbol mode
        for (int i = 0; i < 400; i++)
            applyStimulus(($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) != 0), 1'b0);
        drainAll("random");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
